// File: rtl/fila_pedidos_pkg.sv
// Shared types for the request queue: floor width, FIFO sizing, leg FSM
// encoding and the stored request layout {origem, destino}.
package fila_pedidos_pkg;

    localparam int unsigned ANDAR_W      = 2;
    localparam int unsigned N_ANDARES    = 4;
    localparam int unsigned PROFUNDIDADE = 8;
    localparam int unsigned PTR_W        = 3;

    typedef logic [ANDAR_W-1:0] andar_t;

    typedef struct packed {
        andar_t origem;
        andar_t destino;
    } pedido_t;

    typedef enum logic [1:0] {
        VAZIA         = 2'b00,
        SERVE_ORIGEM  = 2'b01,
        SERVE_DESTINO = 2'b10
    } estado_t;

    // Unsigned range check, widened by one bit so N_ANDARES is representable.
    function automatic logic andarValido(input andar_t andar);
        return {1'b0, andar} < (ANDAR_W+1)'(N_ANDARES);
    endfunction

endpackage

// File: rtl/fila_pedidos_if.sv
// Bundle between the queue (slave) and its users (master): push side,
// movement-UC side (andar_atual/shift) and the status/flag outputs.
interface fila_pedidos_if;
    import fila_pedidos_pkg::*;

    logic                clear;
    logic                novo_pedido;
    andar_t              origem_in;
    andar_t              destino_in;
    andar_t              andar_atual;
    logic                shift;
    logic                temDestino;
    logic                sobe;
    logic                chegouDestino;
    logic                eh_origem;
    andar_t              destino_atual;
    logic                cheia;
    logic                vazia;
    logic [PTR_W:0]      ocupacao;
    logic                pedido_rejeitado;
    logic [1:0]          db_estado;

    modport master (
        output clear, novo_pedido, origem_in, destino_in, andar_atual, shift,
        input  temDestino, sobe, chegouDestino, eh_origem, destino_atual,
               cheia, vazia, ocupacao, pedido_rejeitado, db_estado
    );

    modport slave (
        input  clear, novo_pedido, origem_in, destino_in, andar_atual, shift,
        output temDestino, sobe, chegouDestino, eh_origem, destino_atual,
               cheia, vazia, ocupacao, pedido_rejeitado, db_estado
    );

endinterface

// File: rtl/fila_pedidos_ram.sv
// Dual-pointer register-array FIFO of requests.
// Ports: clock, reset (async, active-high), clear (sync flush), push/dado,
// pop, head (entry at rd pointer), ocupacao, cheia, vazia.
// Push while full is honoured only when a pop happens in the same cycle.
module fila_ram
    import fila_pedidos_pkg::*;
(
    input  logic           clock,
    input  logic           reset,
    input  logic           clear,
    input  logic           push,
    input  pedido_t        dado,
    input  logic           pop,
    output pedido_t        head,
    output logic [PTR_W:0] ocupacao,
    output logic           cheia,
    output logic           vazia
);

    pedido_t          mem [PROFUNDIDADE];
    logic [PTR_W-1:0] wrPtr;
    logic [PTR_W-1:0] rdPtr;
    logic             fazPush;
    logic             fazPop;

    assign vazia   = (ocupacao == '0);
    assign cheia   = (ocupacao == (PTR_W+1)'(PROFUNDIDADE));
    assign fazPop  = pop && !vazia;
    assign fazPush = push && (!cheia || fazPop);
    assign head    = mem[rdPtr];

    // Pointers wrap naturally at PROFUNDIDADE (power of two).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            ocupacao <= '0;
        end else if (clear) begin
            wrPtr    <= '0;
            rdPtr    <= '0;
            ocupacao <= '0;
        end else begin
            if (fazPush) wrPtr <= wrPtr + PTR_W'(1);
            if (fazPop)  rdPtr <= rdPtr + PTR_W'(1);
            case ({fazPush, fazPop})
                2'b10:   ocupacao <= ocupacao + (PTR_W+1)'(1);
                2'b01:   ocupacao <= ocupacao - (PTR_W+1)'(1);
                default: ocupacao <= ocupacao;
            endcase
        end
    end

    // Storage needs no reset: entries are only visible through valid pointers.
    always_ff @(posedge clock) begin
        if (fazPush && !clear) mem[wrPtr] <= dado;
    end

endmodule

// File: rtl/fila_pedidos.sv
// Request queue and dispatcher for uc_movimento. Each request is served as
// a pickup leg (origem) then a dropoff leg (destino); the entry pops after
// the dropoff shift.
// Ports: clock, reset (async, active-high), bus (fila_pedidos_if.slave):
// clear/novo_pedido/origem_in/destino_in/andar_atual/shift in; target flags,
// occupancy, pedido_rejeitado pulse and db_estado out.
module fila_pedidos
    import fila_pedidos_pkg::*;
(
    input  logic          clock,
    input  logic          reset,
    fila_pedidos_if.slave bus
);

    estado_t        estado;
    estado_t        proxEstado;
    pedido_t        novo;
    pedido_t        head;
    logic [PTR_W:0] ocupacao;
    logic           cheia;
    logic           vazia;
    logic           pushValido;
    logic           pushAceito;
    logic           pop;
    logic           rejeitado;

    logic           temDestinoC;
    logic           ehOrigemC;
    andar_t         alvoC;

    assign novo       = '{origem: bus.origem_in, destino: bus.destino_in};
    assign pushValido = bus.novo_pedido && !bus.clear
                        && (bus.origem_in != bus.destino_in)
                        && andarValido(bus.origem_in)
                        && andarValido(bus.destino_in);
    // Pop only on the dropoff leg; the queue is never empty in that state.
    assign pop        = bus.shift && !bus.clear && (estado == SERVE_DESTINO);
    assign pushAceito = pushValido && (!cheia || pop);

    fila_ram uRam (
        .clock    (clock),
        .reset    (reset),
        .clear    (bus.clear),
        .push     (pushValido),
        .dado     (novo),
        .pop      (pop),
        .head     (head),
        .ocupacao (ocupacao),
        .cheia    (cheia),
        .vazia    (vazia)
    );

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado <= VAZIA;
        else       estado <= proxEstado;
    end

    // Next-state logic; transitions look at post-update occupancy.
    always_comb begin
        proxEstado = estado;
        if (bus.clear) begin
            proxEstado = VAZIA;
        end else begin
            case (estado)
                VAZIA:         if (pushAceito) proxEstado = SERVE_ORIGEM;
                SERVE_ORIGEM:  if (bus.shift)  proxEstado = SERVE_DESTINO;
                SERVE_DESTINO: if (bus.shift)
                                   proxEstado = (ocupacao > (PTR_W+1)'(1) || pushAceito)
                                                ? SERVE_ORIGEM : VAZIA;
                default:       proxEstado = VAZIA;
            endcase
        end
    end

    // Target selection from registered state and head entry.
    always_comb begin
        temDestinoC = 1'b0;
        ehOrigemC   = 1'b0;
        alvoC       = '0;
        case (estado)
            SERVE_ORIGEM: begin
                temDestinoC = 1'b1;
                ehOrigemC   = 1'b1;
                alvoC       = head.origem;
            end
            SERVE_DESTINO: begin
                temDestinoC = 1'b1;
                alvoC       = head.destino;
            end
            default: ;
        endcase
    end

    // Refused-push pulse, one cycle after the attempt.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)          rejeitado <= 1'b0;
        else if (bus.clear) rejeitado <= 1'b0;
        else                rejeitado <= bus.novo_pedido && !pushAceito;
    end

    assign bus.temDestino       = temDestinoC;
    assign bus.eh_origem        = ehOrigemC;
    assign bus.destino_atual    = alvoC;
    assign bus.sobe             = temDestinoC && (alvoC > bus.andar_atual);
    assign bus.chegouDestino    = temDestinoC && (alvoC == bus.andar_atual);
    assign bus.cheia            = cheia;
    assign bus.vazia            = vazia;
    assign bus.ocupacao         = ocupacao;
    assign bus.pedido_rejeitado = rejeitado;
    assign bus.db_estado        = estado;

endmodule

// File: tb/tb_fila_pedidos.sv
module tb_fila_pedidos;
    import fila_pedidos_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    fila_pedidos_if bus ();

    fila_pedidos dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int testes = 0;
    int falhas = 0;

    // Reference model: a plain queue of requests plus "on dropoff leg" flag.
    pedido_t q[$];
    bit      legDestino = 1'b0;
    bit      rejM       = 1'b0;

    typedef struct {
        logic        novo;
        logic [2:0]  o;
        logic [2:0]  d;
        logic        sh;
        logic        clr;
        logic [1:0]  andar;
        logic [14:0] esperado;
    } vec_t;

    function automatic logic [14:0] mk(bit tem, bit sobe, bit cheg, bit eho,
                                       logic [1:0] dest, bit ch, bit vz,
                                       logic [3:0] ocup, bit rej, logic [1:0] db);
        return {tem, sobe, cheg, eho, dest, ch, vz, ocup, rej, db};
    endfunction

    function automatic logic [14:0] atual();
        return {bus.temDestino, bus.sobe, bus.chegouDestino, bus.eh_origem,
                bus.destino_atual, bus.cheia, bus.vazia, bus.ocupacao,
                bus.pedido_rejeitado, bus.db_estado};
    endfunction

    function automatic logic [14:0] modelo();
        bit         tem;
        logic [1:0] alvo;
        logic [1:0] db;
        tem  = (q.size() > 0);
        alvo = 2'd0;
        db   = 2'd0;
        if (tem) begin
            alvo = legDestino ? q[0].destino : q[0].origem;
            db   = legDestino ? 2'd2 : 2'd1;
        end
        return mk(tem, tem && (alvo > bus.andar_atual), tem && (alvo == bus.andar_atual),
                  tem && !legDestino, alvo, q.size() == 8, q.size() == 0,
                  4'(q.size()), rejM, db);
    endfunction

    task automatic check(input string nome, input logic [14:0] act, input logic [14:0] exp);
        testes++;
        if (act !== exp) begin
            falhas++;
            $display("FAIL %s: got %b required %b (tem,sobe,cheg,eho,dest,cheia,vazia,ocup,rej,db)",
                     nome, act, exp);
        end
    endtask

    task automatic checkBits(input string nome, input logic [7:0] act, input logic [7:0] exp);
        testes++;
        if (act !== exp) begin
            falhas++;
            $display("FAIL %s: got %h required %h", nome, act, exp);
        end
    endtask

    // Advance the model with the inputs the DUT samples at this edge.
    task automatic atualizaModelo();
        bit doPop;
        bit ok;
        if (reset || bus.clear) begin
            q.delete();
            legDestino = 1'b0;
            rejM       = 1'b0;
        end else begin
            doPop = bus.shift && (q.size() > 0) && legDestino;
            ok    = bus.novo_pedido && (bus.origem_in != bus.destino_in)
                    && (int'(bus.origem_in) < N_ANDARES) && (int'(bus.destino_in) < N_ANDARES)
                    && (q.size() < 8 || doPop);
            if (bus.shift && q.size() > 0) legDestino = !legDestino;
            if (doPop) void'(q.pop_front());
            if (ok) q.push_back('{origem: bus.origem_in, destino: bus.destino_in});
            rejM = bus.novo_pedido && !ok;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        atualizaModelo();
        #1;
    endtask

    task automatic idle();
        bus.novo_pedido = 1'b0;
        bus.shift       = 1'b0;
        bus.clear       = 1'b0;
    endtask

    task automatic pushReq(input logic [1:0] o, input logic [1:0] d);
        idle();
        bus.novo_pedido = 1'b1;
        bus.origem_in   = o;
        bus.destino_in  = d;
        tick();
        idle();
    endtask

    task automatic doShift();
        idle();
        bus.shift = 1'b1;
        tick();
        idle();
    endtask

    task automatic pushAleatorio();
        logic [1:0] o;
        logic [1:0] d;
        o = 2'($urandom_range(0, 3));
        d = 2'((int'(o) + int'($urandom_range(1, 3))) % 4);
        pushReq(o, d);
    endtask

    vec_t    tab [8];
    pedido_t proximo;
    int      guarda;

    initial begin
        tab[0] = '{1'b1, 3'd1, 3'd3, 1'b0, 1'b0, 2'd0, mk(1,1,0,1,2'd1,0,0,4'd1,0,2'd1)};
        tab[1] = '{1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 2'd1, mk(1,0,1,1,2'd1,0,0,4'd1,0,2'd1)};
        tab[2] = '{1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 2'd1, mk(1,1,0,0,2'd3,0,0,4'd1,0,2'd2)};
        tab[3] = '{1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 2'd3, mk(1,0,1,0,2'd3,0,0,4'd1,0,2'd2)};
        tab[4] = '{1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 2'd3, mk(0,0,0,0,2'd0,0,1,4'd0,0,2'd0)};
        tab[5] = '{1'b1, 3'd2, 3'd2, 1'b0, 1'b0, 2'd3, mk(0,0,0,0,2'd0,0,1,4'd0,1,2'd0)};
        // Floor 4 does not fit the 2-bit port and arrives as 0 -> (0,0), refused.
        tab[6] = '{1'b1, 3'd0, 3'd4, 1'b0, 1'b0, 2'd3, mk(0,0,0,0,2'd0,0,1,4'd0,1,2'd0)};
        tab[7] = '{1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 2'd3, mk(0,0,0,0,2'd0,0,1,4'd0,0,2'd0)};

        idle();
        bus.origem_in   = '0;
        bus.destino_in  = '0;
        bus.andar_atual = '0;
        tick();
        tick();
        check("reset_state", atual(), mk(0,0,0,0,2'd0,0,1,4'd0,0,2'd0));
        reset = 1'b0;
        tick();
        check("after_reset", atual(), mk(0,0,0,0,2'd0,0,1,4'd0,0,2'd0));

        // Tests 1, 2 and 4 as a vector table.
        for (int i = 0; i < 8; i++) begin
            bus.novo_pedido = tab[i].novo;
            bus.origem_in   = 2'(tab[i].o);
            bus.destino_in  = 2'(tab[i].d);
            bus.shift       = tab[i].sh;
            bus.clear       = tab[i].clr;
            bus.andar_atual = tab[i].andar;
            tick();
            check($sformatf("vec%0d", i), atual(), tab[i].esperado);
        end
        idle();

        // Test 3: fill through the pointer wrap, overflow, drain in order.
        bus.andar_atual = 2'd2;
        for (int i = 0; i < 8; i++) begin
            pushAleatorio();
            check("fill", atual(), modelo());
        end
        checkBits("full_ocup", {3'b0, bus.cheia, bus.ocupacao}, 8'h18);
        pushReq(2'd0, 2'd1);
        checkBits("ovf_rej", {3'b0, bus.pedido_rejeitado, bus.ocupacao}, 8'h18);
        tick();
        checkBits("ovf_pulse", {7'b0, bus.pedido_rejeitado}, 8'h00);
        guarda = 0;
        while (q.size() > 0 && guarda < 40) begin
            doShift();
            check("drain", atual(), modelo());
            guarda++;
        end
        check("drain_done", atual(), mk(0,0,0,0,2'd0,0,1,4'd0,0,2'd0));

        // Test 5: full queue on dropoff leg, push and shift together.
        for (int i = 0; i < 8; i++) pushAleatorio();
        doShift();
        checkBits("full_destino", {2'b0, bus.db_estado, bus.ocupacao}, 8'h28);
        proximo = q[1];
        bus.novo_pedido = 1'b1;
        bus.origem_in   = 2'd3;
        bus.destino_in  = 2'd0;
        bus.shift       = 1'b1;
        tick();
        idle();
        checkBits("push_pop", {bus.db_estado, bus.destino_atual, bus.ocupacao},
                  {2'd1, proximo.origem, 4'd8});
        check("push_pop_model", atual(), modelo());

        // Test 6: clear beats shift on the dropoff leg.
        bus.clear = 1'b1;
        tick();
        idle();
        for (int i = 0; i < 3; i++) pushAleatorio();
        doShift();
        checkBits("three_destino", {2'b0, bus.db_estado, bus.ocupacao}, 8'h23);
        bus.clear = 1'b1;
        bus.shift = 1'b1;
        tick();
        idle();
        check("clear_shift", atual(), mk(0,0,0,0,2'd0,0,1,4'd0,0,2'd0));

        // Asynchronous reset between edges.
        pushAleatorio();
        pushAleatorio();
        #2;
        reset = 1'b1;
        #1;
        check("async_reset", atual(), mk(0,0,0,0,2'd0,0,1,4'd0,0,2'd0));
        tick();
        reset = 1'b0;
        tick();
        check("post_async", atual(), modelo());

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            bus.novo_pedido = ($urandom_range(0, 99) < 45);
            bus.origem_in   = 2'($urandom_range(0, 3));
            bus.destino_in  = 2'($urandom_range(0, 3));
            bus.shift       = ($urandom_range(0, 99) < 30);
            bus.clear       = ($urandom_range(0, 99) < 2);
            bus.andar_atual = 2'($urandom_range(0, 3));
            tick();
            check("random", atual(), modelo());
        end
        idle();

        $display("[TB] %0d tests run, %0d failed", testes, falhas);
        $finish;
    end

endmodule
